fifo_burst_reader: RTL and testbench

- Read-side controller for the team's single-clock FIFO (normal mode, 16-bit data, 256 deep, 8-bit usedw).
- Drains the FIFO in bursts and presents words on a valid/ready stream with a last marker.
- Downstream packetisers and DMA writers consume the stream.
- Owns fifo_rdreq; a separate producer drives wrreq and data.

---
 rtl/fifo_rd_pkg.sv | 14 +
 rtl/out_skid_buf.sv | 59 +++++
 rtl/fifo_burst_reader.sv | 111 +++++++++++
 tb/tb_fifo_burst_reader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and default sizing for the FIFO burst reader.
package fifo_rd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_e;

    localparam int unsigned DEF_DATA_W    = 16;
    localparam int unsigned DEF_USEDW_W   = 8;
    localparam int unsigned DEF_BURST_LEN = 16;
    localparam int unsigned DEF_TIMEOUT   = 64;

endpackage

// File: rtl/out_skid_buf.sv
// Two-entry data+last output buffer; slot 0 is the stream head.
module out_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic              o_valid,
    output logic [1:0]        o_occ
);

    logic [DATA_W-1:0] r_data0, r_data1;
    logic              r_last0, r_last1;
    logic [1:0]        r_occ;
    logic              w_pop;
    logic [1:0]        w_base;

    assign w_pop  = (r_occ != 2'd0) && i_ready;
    assign w_base = r_occ - {1'b0, w_pop};

    // Pop shifts slot 1 forward; a same-cycle push then lands behind the survivor.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data0 <= '0;
            r_data1 <= '0;
            r_last0 <= 1'b0;
            r_last1 <= 1'b0;
            r_occ   <= '0;
        end else begin
            if (w_pop) begin
                r_data0 <= r_data1;
                r_last0 <= (r_occ == 2'd2) ? r_last1 : 1'b0;
            end
            if (i_push) begin
                if (w_base == 2'd0) begin
                    r_data0 <= i_data;
                    r_last0 <= i_last;
                end else begin
                    r_data1 <= i_data;
                    r_last1 <= i_last;
                end
            end
            r_occ <= r_occ + {1'b0, i_push} - {1'b0, w_pop};
        end
    end

    assign o_data  = r_data0;
    assign o_last  = r_last0;
    assign o_valid = (r_occ != 2'd0);
    assign o_occ   = r_occ;

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst read controller for a single-clock FIFO with a valid/ready/last output stream.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned USEDW_W   = DEF_USEDW_W,
    parameter int unsigned BURST_LEN = DEF_BURST_LEN,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [DATA_W-1:0]  fifo_q,
    input  logic               fifo_empty,
    input  logic               fifo_full,
    input  logic [USEDW_W-1:0] fifo_usedw,
    output logic               fifo_rdreq,
    output logic [DATA_W-1:0]  m_data,
    output logic               m_valid,
    output logic               m_last,
    input  logic               m_ready,
    output logic               busy,
    output logic [15:0]        burst_cnt
);

    localparam int unsigned   LW         = USEDW_W + 1;
    localparam int unsigned   TW         = $clog2(TIMEOUT + 1);
    localparam logic [LW-1:0] LP_BURST   = LW'(BURST_LEN);
    localparam logic [TW-1:0] LP_TIMEOUT = TW'(TIMEOUT);

    rd_state_e     r_state;
    logic [TW-1:0] r_timer;
    logic [LW-1:0] r_req_left, r_out_left;
    logic          r_inflight, r_inflight_last, r_busy;
    logic [15:0]   r_burst_cnt;

    logic [LW-1:0] w_level, w_take;
    logic          w_start, w_pop, w_rdreq, w_valid, w_last;
    logic [1:0]    w_occ;
    logic [2:0]    w_fill;

    // usedw wraps to 0 when full, so full forces the top level bit.
    assign w_level = fifo_full ? {1'b1, {USEDW_W{1'b0}}} : {1'b0, fifo_usedw};
    assign w_take  = (w_level < LP_BURST) ? w_level : LP_BURST;
    assign w_start = (r_state == IDLE) && enable && (w_level != '0) &&
                     ((w_level >= LP_BURST) || ((r_timer == LP_TIMEOUT) && !fifo_empty));
    assign w_pop   = w_valid && m_ready;
    assign w_fill  = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_rdreq = (r_state == BURST) && (r_req_left != '0) && !fifo_empty && (w_fill < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_timer         <= '0;
            r_req_left      <= '0;
            r_out_left      <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_busy          <= 1'b0;
            r_burst_cnt     <= '0;
        end else begin
            r_inflight      <= w_rdreq;
            r_inflight_last <= w_rdreq && (r_req_left == LW'(1));
            if (w_rdreq) r_req_left <= r_req_left - LW'(1);
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state    <= BURST;
                        r_busy     <= 1'b1;
                        r_req_left <= w_take;
                        r_out_left <= w_take;
                        r_timer    <= '0;
                    end else if (fifo_empty) begin
                        r_timer <= '0;
                    end else if (r_timer != LP_TIMEOUT) begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                BURST: begin
                    if (w_pop) r_out_left <= r_out_left - LW'(1);
                    if (w_pop && (r_out_left == LW'(1))) begin
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                        r_burst_cnt <= r_burst_cnt + 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    out_skid_buf #(.DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_data  (fifo_q),
        .i_last  (r_inflight_last),
        .i_ready (m_ready),
        .o_data  (m_data),
        .o_last  (w_last),
        .o_valid (w_valid),
        .o_occ   (w_occ)
    );

    assign fifo_rdreq = w_rdreq;
    assign m_valid    = w_valid;
    assign m_last     = w_last;
    assign busy       = r_busy;
    assign burst_cnt  = r_burst_cnt;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed scenarios with random data/ready against a queue-based FIFO and stream scoreboard.
module tb_fifo_burst_reader;

    localparam int unsigned DW = 16, UW = 8, BL = 16, TO = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b1, enable = 1'b0, m_ready = 1'b0;
    logic [DW-1:0]  fifo_q = '0;
    logic           fifo_empty = 1'b1, fifo_full = 1'b0;
    logic [UW-1:0]  fifo_usedw = '0;
    logic           fifo_rdreq, m_valid, m_last, busy;
    logic [DW-1:0]  m_data;
    logic [15:0]    burst_cnt;

    logic           wr_req = 1'b0, do_flush = 1'b0;
    logic [DW-1:0]  wr_data = '0;
    logic [DW-1:0]  fq[$];
    int             n_rd = 0;

    logic [DW-1:0]  sb[$];
    int n_tests = 0, n_fail = 0;
    int n_del = 0, n_rdreq = 0, n_words = 0, idx = 0, exp_blen = 16, cyc = 0;
    int first_rd = -1, first_v = -1, first_ne = -1, first_l16 = -1;
    int base_rdreq = 0, base_words = 0;
    logic stall_prev = 1'b0, prev_last = 1'b0, drop_pending = 1'b0, chk_nogap = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always #5 clk = ~clk;

    fifo_burst_reader #(.DATA_W(DW), .USEDW_W(UW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_q     (fifo_q),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fifo_usedw (fifo_usedw),
        .fifo_rdreq (fifo_rdreq),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .busy       (busy),
        .burst_cnt  (burst_cnt)
    );

    // Show-ahead-free FIFO: q appears the cycle after rdreq; flags registered.
    always @(posedge clk) begin
        if (do_flush) begin
            fq.delete();
        end else begin
            if (fifo_rdreq === 1'b1 && fq.size() != 0) begin
                fifo_q <= fq.pop_front();
                n_rd++;
            end
            if (wr_req && fq.size() < 256) fq.push_back(wr_data);
        end
        fifo_empty <= (fq.size() == 0);
        fifo_full  <= (fq.size() == 256);
        fifo_usedw <= UW'(fq.size());
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        logic exp_last;
        if (rst) begin
            stall_prev   = 1'b0;
            idx          = 0;
            drop_pending = 1'b1;
        end else begin
            if (drop_pending) begin
                while (n_del < n_rd && sb.size() != 0) begin
                    void'(sb.pop_front());
                    n_del++;
                end
                drop_pending = 1'b0;
            end
            if (fifo_rdreq) begin
                n_rdreq++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (m_valid && first_v < 0) first_v = cyc;
            if (!fifo_empty && first_ne < 0) first_ne = cyc;
            if (fifo_usedw == 8'd16 && first_l16 < 0) first_l16 = cyc;
            check("rd_while_empty", 32'(fifo_rdreq & fifo_empty), 0);
            if (!busy) check("rd_while_idle", 32'(fifo_rdreq), 0);
            if (stall_prev) begin
                check("stall_valid", 32'(m_valid), 1);
                check("stall_data", 32'(m_data), 32'(prev_data));
                check("stall_last", 32'(m_last), 32'(prev_last));
            end
            if (chk_nogap && idx != 0 && m_ready) check("burst_gap", 32'(m_valid), 1);
            if (m_valid && m_ready) begin
                exp_last = (idx == exp_blen - 1);
                if (sb.size() != 0) begin
                    check("data", 32'(m_data), 32'(sb.pop_front()));
                    n_del++;
                end else begin
                    check("data_extra", 32'(m_data), 32'h1_0000);
                end
                check("last", 32'(m_last), 32'(exp_last));
                idx = exp_last ? 0 : idx + 1;
                n_words++;
            end
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic write_words(input int n);
        for (int i = 0; i < n; i++) begin
            wr_data = DW'($urandom);
            wr_req  = 1'b1;
            sb.push_back(wr_data);
            step();
        end
        wr_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; m_ready = 1'b0; chk_nogap = 1'b0;
        step();
        check("rst_rdreq", 32'(fifo_rdreq), 0);
        check("rst_valid", 32'(m_valid), 0);
        check("rst_last", 32'(m_last), 0);
        check("rst_data", 32'(m_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cnt", 32'(burst_cnt), 0);
        rst = 1'b0;
        step();
        first_rd = -1; first_v = -1; first_ne = -1; first_l16 = -1;
        base_rdreq = n_rdreq; base_words = n_words;
    endtask

    initial begin
        // 1: full FIFO drained as 16 back-to-back bursts of 16
        do_reset();
        write_words(256);
        step();
        exp_blen = 16; enable = 1'b1; m_ready = 1'b1; chk_nogap = 1'b1;
        for (int k = 0; k < 800 && burst_cnt != 16'd16; k++) step();
        check("t1_bursts", 32'(burst_cnt), 16);
        check("t1_busy", 32'(busy), 0);
        check("t1_words", 32'(n_words - base_words), 256);
        check("t1_latency", 32'(first_v - first_rd), 2);
        check("t1_empty", 32'(fifo_empty), 1);

        // 2: short fill flushed after the idle timeout
        do_reset();
        exp_blen = 5; enable = 1'b1; m_ready = 1'b1;
        write_words(5);
        for (int k = 0; k < 300 && burst_cnt != 16'd1; k++) step();
        check("t2_bursts", 32'(burst_cnt), 1);
        check("t2_timeout", 32'(first_rd - first_ne), TO + 1);
        check("t2_words", 32'(n_words - base_words), 5);
        check("t2_busy", 32'(busy), 0);

        // 3: random backpressure over 64 words
        do_reset();
        write_words(64);
        exp_blen = 16; enable = 1'b1;
        for (int k = 0; k < 3000 && burst_cnt != 16'd4; k++) begin
            m_ready = 1'($urandom_range(0, 1));
            step();
        end
        m_ready = 1'b1;
        check("t3_bursts", 32'(burst_cnt), 4);
        check("t3_words", 32'(n_words - base_words), 64);
        check("t3_left", 32'(sb.size()), 0);

        // 4: reset while the 7th word of the second burst is presented
        do_reset();
        write_words(48);
        exp_blen = 16; enable = 1'b1; m_ready = 1'b1;
        for (int k = 0; k < 300 && !(burst_cnt == 16'd1 && idx == 6 && m_valid); k++) step();
        check("t4_reached", 32'(idx), 6);
        rst = 1'b1;
        step();
        check("t4_valid", 32'(m_valid), 0);
        check("t4_busy", 32'(busy), 0);
        check("t4_cnt", 32'(burst_cnt), 0);
        check("t4_rdreq", 32'(fifo_rdreq), 0);
        rst = 1'b0;
        base_words = n_words;
        for (int k = 0; k < 300 && burst_cnt != 16'd1; k++) step();
        enable = 1'b0;
        check("t4_bursts", 32'(burst_cnt), 1);
        check("t4_words", 32'(n_words - base_words), 16);
        step(); step();
        do_flush = 1'b1;
        step();
        do_flush = 1'b0;
        sb.delete();

        // 5: enable dropped mid-burst, then restored
        do_reset();
        write_words(40);
        exp_blen = 16; enable = 1'b1; m_ready = 1'b1;
        for (int k = 0; k < 300 && idx != 4; k++) step();
        enable = 1'b0;
        for (int k = 0; k < 300 && burst_cnt != 16'd1; k++) step();
        check("t5_b1_words", 32'(n_words - base_words), 16);
        base_rdreq = n_rdreq;
        for (int k = 0; k < 100; k++) step();
        check("t5_no_rd", 32'(n_rdreq - base_rdreq), 0);
        check("t5_hold_cnt", 32'(burst_cnt), 1);
        check("t5_hold_busy", 32'(busy), 0);
        enable = 1'b1;
        for (int k = 0; k < 300 && burst_cnt != 16'd2; k++) step();
        check("t5_b2", 32'(burst_cnt), 2);
        exp_blen = 8;
        for (int k = 0; k < 300 && burst_cnt != 16'd3; k++) step();
        check("t5_b3", 32'(burst_cnt), 3);
        check("t5_words", 32'(n_words - base_words), 40);

        // 6: level reaching exactly BURST_LEN starts one burst of exactly 16 reads
        do_reset();
        exp_blen = 16; enable = 1'b1; m_ready = 1'b1;
        write_words(16);
        for (int k = 0; k < 300 && burst_cnt != 16'd1; k++) step();
        check("t6_start", 32'(first_rd - first_l16), 1);
        check("t6_rdreqs", 32'(n_rdreq - base_rdreq), 16);
        check("t6_empty", 32'(fifo_empty), 1);
        for (int k = 0; k < 20; k++) step();
        check("t6_no_17th", 32'(n_rdreq - base_rdreq), 16);
        check("t6_cnt", 32'(burst_cnt), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
